// File: rtl/ahb_arb_pkg.sv
// Shared constants and types for the AHB master arbiter.
package ahb_arb_pkg;

   localparam logic [1:0] HTRANS_IDLE   = 2'b00;
   localparam logic [1:0] HTRANS_BUSY   = 2'b01;
   localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
   localparam logic [1:0] HTRANS_SEQ    = 2'b11;

   typedef enum logic [1:0] {
      ARB_IDLE     = 2'd0,
      ARB_OWN      = 2'd1,
      ARB_HANDOVER = 2'd2
   } arb_state_t;

   // Master index width; never below one bit so a two-master build still has a select.
   function automatic int midx_w(input int n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/rr_picker.sv
// Combinational round-robin search: first requester at or above ptr, wrapping.
module rr_picker
   import ahb_arb_pkg::*;
#(
   parameter int N = 4
) (
   input  logic [N-1:0]           req,
   input  logic [midx_w(N)-1:0]   ptr,
   output logic [midx_w(N)-1:0]   winner,
   output logic                   any_req
);

   localparam int W = midx_w(N);

   logic [W-1:0] idx;
   logic         found;

   always_comb begin
      winner = '0;
      found  = 1'b0;
      idx    = '0;
      for (int i = 0; i < N; i++) begin
         idx = W'((int'(ptr) + i) % N);
         if (!found && req[idx]) begin
            winner = idx;
            found  = 1'b1;
         end
      end
   end

   assign any_req = |req;

endmodule

// File: rtl/ahb_master_arbiter.sv
// Round-robin arbiter sharing one AHB slave port between several masters.
//
// state        | meaning
// ARB_IDLE     | nobody owns the bus, Htrans forced IDLE
// ARB_OWN      | Hmaster drives address/control toward the bridge
// ARB_HANDOVER | grant withdrawn, previous data phase finishing
module ahb_master_arbiter
   import ahb_arb_pkg::*;
#(
   parameter int NUM_MASTERS = 4,
   parameter int ADDR_W      = 32,
   parameter int DATA_W      = 32,
   parameter int MAX_HOLD    = 16
) (
   input  logic                            Hclk,
   input  logic                            Hreset,
   input  logic [NUM_MASTERS-1:0]          Hbusreq,
   input  logic [NUM_MASTERS*ADDR_W-1:0]   M_Haddr,
   input  logic [NUM_MASTERS*DATA_W-1:0]   M_Hwdata,
   input  logic [NUM_MASTERS-1:0]          M_Hwrite,
   input  logic [NUM_MASTERS*2-1:0]        M_Htrans,
   input  logic                            Hreadyout,
   output logic [NUM_MASTERS-1:0]          Hgrant,
   output logic [midx_w(NUM_MASTERS)-1:0]  Hmaster,
   output logic [ADDR_W-1:0]               Haddr,
   output logic [DATA_W-1:0]               Hwdata,
   output logic                            Hwrite,
   output logic [1:0]                      Htrans,
   output logic                            Hreadyin
);

   localparam int MIDX_W = midx_w(NUM_MASTERS);
   localparam int CNT_W  = $clog2(MAX_HOLD + 1);
   localparam logic [CNT_W-1:0]       HOLD_MAX  = CNT_W'(MAX_HOLD);
   localparam logic [NUM_MASTERS-1:0] GRANT_ONE = NUM_MASTERS'(1);
   localparam logic [MIDX_W-1:0]      LAST_IDX  = MIDX_W'(NUM_MASTERS - 1);

   logic [ADDR_W-1:0] addr_a  [NUM_MASTERS];
   logic [DATA_W-1:0] wdata_a [NUM_MASTERS];
   logic [1:0]        trans_a [NUM_MASTERS];

   for (genvar g = 0; g < NUM_MASTERS; g++) begin : g_unpack
      assign addr_a[g]  = M_Haddr[g*ADDR_W +: ADDR_W];
      assign wdata_a[g] = M_Hwdata[g*DATA_W +: DATA_W];
      assign trans_a[g] = M_Htrans[g*2 +: 2];
   end

   arb_state_t              state, state_nxt;
   logic [NUM_MASTERS-1:0]  grant_nxt;
   logic [MIDX_W-1:0]       master_nxt;
   logic [MIDX_W-1:0]       ptr_q, ptr_nxt;
   logic [CNT_W-1:0]        beat_cnt, cnt_nxt;
   logic [MIDX_W-1:0]       hmaster_data;
   logic                    data_vld;

   logic [MIDX_W-1:0]       winner;
   logic                    any_req;
   logic [1:0]              owner_trans;
   logic                    owner_idle, owner_beat, others_req, release_own;

   rr_picker #(.N(NUM_MASTERS)) u_picker (
      .req     (Hbusreq),
      .ptr     (ptr_q),
      .winner  (winner),
      .any_req (any_req)
   );

   assign owner_trans = trans_a[Hmaster];
   assign owner_idle  = (owner_trans == HTRANS_IDLE);
   assign owner_beat  = !(owner_trans inside {HTRANS_IDLE, HTRANS_BUSY});
   assign others_req  = |(Hbusreq & ~Hgrant);
   // Only an IDLE address phase is a safe place to break ownership.
   assign release_own = owner_idle &&
                        (!Hbusreq[Hmaster] || (beat_cnt >= HOLD_MAX && others_req));

   always_comb begin
      state_nxt  = state;
      grant_nxt  = Hgrant;
      master_nxt = Hmaster;
      ptr_nxt    = ptr_q;
      cnt_nxt    = beat_cnt;
      if (Hreadyout) begin
         case (state)
            ARB_IDLE, ARB_HANDOVER: begin
               if (any_req) begin
                  grant_nxt  = GRANT_ONE << winner;
                  master_nxt = winner;
                  ptr_nxt    = (winner == LAST_IDX) ? '0 : winner + 1'b1;
                  cnt_nxt    = '0;
                  state_nxt  = ARB_OWN;
               end else begin
                  state_nxt  = ARB_IDLE;
               end
            end
            ARB_OWN: begin
               if (owner_beat && beat_cnt < HOLD_MAX)
                  cnt_nxt = beat_cnt + 1'b1;
               if (release_own) begin
                  grant_nxt = '0;
                  state_nxt = ARB_HANDOVER;
               end
            end
            default: begin
               grant_nxt = '0;
               state_nxt = ARB_IDLE;
            end
         endcase
      end
   end

   always_ff @(posedge Hclk or posedge Hreset) begin
      if (Hreset) begin
         state        <= ARB_IDLE;
         Hgrant       <= '0;
         Hmaster      <= '0;
         ptr_q        <= '0;
         beat_cnt     <= '0;
         hmaster_data <= '0;
         data_vld     <= 1'b0;
      end else begin
         state    <= state_nxt;
         Hgrant   <= grant_nxt;
         Hmaster  <= master_nxt;
         ptr_q    <= ptr_nxt;
         beat_cnt <= cnt_nxt;
         if (Hreadyout) begin
            hmaster_data <= Hmaster;
            data_vld     <= 1'b1;
         end
      end
   end

   // Write data stays zero until the data-phase owner has been loaded once after reset.
   assign Hwdata   = data_vld ? wdata_a[hmaster_data] : '0;
   assign Haddr    = (state == ARB_OWN) ? addr_a[Hmaster]   : '0;
   assign Hwrite   = (state == ARB_OWN) ? M_Hwrite[Hmaster] : 1'b0;
   assign Htrans   = (state == ARB_OWN) ? owner_trans       : HTRANS_IDLE;
   assign Hreadyin = Hreadyout;

endmodule

// File: tb/tb_ahb_master_arbiter.sv
// Directed self-checking bench for ahb_master_arbiter (4 masters, MAX_HOLD=4).
module tb_ahb_master_arbiter;
   import ahb_arb_pkg::*;

   logic         Hclk = 1'b0;
   logic         Hreset;
   logic [3:0]   Hbusreq;
   logic [3:0]   M_Hwrite;
   logic         Hreadyout;
   logic [3:0]   Hgrant;
   logic [1:0]   Hmaster;
   logic [31:0]  Haddr;
   logic [31:0]  Hwdata;
   logic         Hwrite;
   logic [1:0]   Htrans;
   logic         Hreadyin;

   logic [31:0]  addr  [4];
   logic [31:0]  wdata [4];
   logic [1:0]   trans [4];
   wire  [127:0] M_Haddr;
   wire  [127:0] M_Hwdata;
   wire  [7:0]   M_Htrans;

   for (genvar g = 0; g < 4; g++) begin : g_pack
      assign M_Haddr[g*32 +: 32]  = addr[g];
      assign M_Hwdata[g*32 +: 32] = wdata[g];
      assign M_Htrans[g*2 +: 2]   = trans[g];
   end

   int n_cmp = 0;
   int n_err = 0;

   ahb_master_arbiter #(
      .NUM_MASTERS (4),
      .ADDR_W      (32),
      .DATA_W      (32),
      .MAX_HOLD    (4)
   ) dut (
      .Hclk      (Hclk),
      .Hreset    (Hreset),
      .Hbusreq   (Hbusreq),
      .M_Haddr   (M_Haddr),
      .M_Hwdata  (M_Hwdata),
      .M_Hwrite  (M_Hwrite),
      .M_Htrans  (M_Htrans),
      .Hreadyout (Hreadyout),
      .Hgrant    (Hgrant),
      .Hmaster   (Hmaster),
      .Haddr     (Haddr),
      .Hwdata    (Hwdata),
      .Hwrite    (Hwrite),
      .Htrans    (Htrans),
      .Hreadyin  (Hreadyin)
   );

   always #5 Hclk = ~Hclk;

   task automatic tick();
      @(posedge Hclk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      assert (obs === exp)
      else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic clear_inputs();
      Hbusreq   = 4'b0000;
      M_Hwrite  = 4'b0000;
      Hreadyout = 1'b1;
      for (int i = 0; i < 4; i++) begin
         addr[i]  = 32'h0;
         wdata[i] = 32'h0;
         trans[i] = HTRANS_IDLE;
      end
   endtask

   task automatic do_reset();
      clear_inputs();
      Hreset = 1'b1;
      #3;
      Hreset = 1'b0;
   endtask

   logic [3:0] exp_g;

   initial begin
      Hreset = 1'b1;
      clear_inputs();
      #2;
      chk("rst_grant",  Hgrant,    0);
      chk("rst_master", Hmaster,   0);
      chk("rst_trans",  Htrans,    0);
      chk("rst_addr",   Haddr,     0);
      chk("rst_write",  Hwrite,    0);
      chk("rst_wdata",  Hwdata,    0);
      chk("rst_state",  dut.state, ARB_IDLE);
      wdata[0] = 32'h5555_0000;
      #1;
      chk("rst_wdata_gated", Hwdata, 0);
      tick();
      do_reset();

      // single request, write address then data one cycle later
      Hbusreq = 4'b0010;
      tick();
      chk("t1_grant",  Hgrant,    4'b0010);
      chk("t1_master", Hmaster,   1);
      chk("t1_state",  dut.state, ARB_OWN);
      trans[1] = HTRANS_NONSEQ; addr[1] = 32'h8000_0004; M_Hwrite[1] = 1'b1;
      #1;
      chk("t1_haddr",  Haddr,  32'h8000_0004);
      chk("t1_htrans", Htrans, HTRANS_NONSEQ);
      chk("t1_hwrite", Hwrite, 1);
      tick();
      trans[1] = HTRANS_IDLE; M_Hwrite[1] = 1'b0; Hbusreq = 4'b0000;
      wdata[1] = 32'hA5A5_A5A5; wdata[0] = 32'h0BAD_0BAD;
      #1;
      chk("t1_hwdata",     Hwdata, 32'hA5A5_A5A5);
      chk("t1_trans_idle", Htrans, HTRANS_IDLE);
      tick();
      chk("t1_rel_grant",  Hgrant,    0);
      chk("t1_rel_state",  dut.state, ARB_HANDOVER);
      chk("t1_rel_wdata",  Hwdata,    32'hA5A5_A5A5);
      tick();
      chk("t1_back_idle",  dut.state, ARB_IDLE);

      // all four request: 0,1,2,3,0 with an IDLE gap between owners
      do_reset();
      Hbusreq = 4'b1111;
      addr[0] = 32'h2000_0000; addr[1] = 32'h2000_0000;
      addr[2] = 32'h2000_0000; addr[3] = 32'h2000_0000;
      tick();
      for (int k = 0; k < 5; k++) begin
         int e;
         e = k % 4;
         exp_g = 4'b0001 << e;
         chk($sformatf("t2_grant%0d", k),  Hgrant,  exp_g);
         chk($sformatf("t2_master%0d", k), Hmaster, e);
         trans[e] = HTRANS_NONSEQ;
         addr[e]  = 32'h1000_0000 | e;
         #1;
         chk($sformatf("t2_addr%0d", k), Haddr, 32'h1000_0000 | e);
         tick();
         trans[e] = HTRANS_IDLE;
         Hbusreq[e] = 1'b0;
         tick();
         chk($sformatf("t2_gap_grant%0d", k), Hgrant, 0);
         trans[e] = HTRANS_NONSEQ;
         #1;
         chk($sformatf("t2_gap_trans%0d", k), Htrans, HTRANS_IDLE);
         chk($sformatf("t2_gap_addr%0d", k),  Haddr,  0);
         trans[e] = HTRANS_IDLE;
         addr[e]  = 32'h2000_0000;
         Hbusreq[e] = 1'b1;
         tick();
      end

      // burst protection: request dropped mid-burst, BUSY inside the burst
      do_reset();
      Hbusreq = 4'b0001;
      addr[0] = 32'h2000_0000;
      tick();
      chk("t3_grant0", Hgrant, 4'b0001);
      trans[0] = HTRANS_NONSEQ; Hbusreq = 4'b0101;
      tick();
      trans[0] = HTRANS_SEQ; Hbusreq = 4'b0100;
      tick();
      chk("t3_hold_b2", Hgrant, 4'b0001);
      trans[0] = HTRANS_BUSY;
      tick();
      chk("t3_hold_busy", Hgrant, 4'b0001);
      trans[0] = HTRANS_SEQ;
      tick();
      chk("t3_hold_b3", Hgrant, 4'b0001);
      tick();
      chk("t3_hold_b4", Hgrant, 4'b0001);
      trans[0] = HTRANS_IDLE;
      tick();
      chk("t3_release", Hgrant, 0);
      trans[0] = HTRANS_NONSEQ;
      #1;
      chk("t3_ho_trans", Htrans, HTRANS_IDLE);
      chk("t3_ho_addr",  Haddr,  0);
      tick();
      trans[0] = HTRANS_IDLE;
      chk("t3_grant2",  Hgrant,  4'b0100);
      chk("t3_master2", Hmaster, 2);

      // MAX_HOLD=4: early IDLE keeps the bus, IDLE after saturation yields
      do_reset();
      Hbusreq = 4'b0001;
      tick();
      chk("t4_grant0", Hgrant, 4'b0001);
      trans[0] = HTRANS_NONSEQ; Hbusreq = 4'b1001;
      tick();
      trans[0] = HTRANS_SEQ;
      tick();
      trans[0] = HTRANS_IDLE;
      tick();
      chk("t4_hold_below_max", Hgrant, 4'b0001);
      trans[0] = HTRANS_NONSEQ;
      tick();
      trans[0] = HTRANS_SEQ;
      tick();
      tick();
      chk("t4_beat_sat", dut.beat_cnt, 4);
      chk("t4_hold_seq", Hgrant, 4'b0001);
      trans[0] = HTRANS_IDLE;
      tick();
      chk("t4_release", Hgrant, 0);
      tick();
      chk("t4_grant3",  Hgrant,  4'b1000);
      chk("t4_master3", Hmaster, 3);

      // wait states during master 1's data phase
      do_reset();
      Hbusreq = 4'b0010;
      tick();
      trans[1] = HTRANS_NONSEQ; M_Hwrite[1] = 1'b1; addr[1] = 32'h3000_0010;
      tick();
      trans[1] = HTRANS_IDLE; M_Hwrite[1] = 1'b0; Hbusreq = 4'b0100;
      wdata[1] = 32'h1234_5678; wdata[0] = 32'hFFFF_0000;
      Hreadyout = 1'b0;
      for (int i = 0; i < 3; i++) begin
         tick();
         chk($sformatf("t5_wait_grant%0d", i), Hgrant,    4'b0010);
         chk($sformatf("t5_wait_wdata%0d", i), Hwdata,    32'h1234_5678);
         chk($sformatf("t5_wait_state%0d", i), dut.state, ARB_OWN);
         chk($sformatf("t5_readyin%0d", i),    Hreadyin,  0);
      end
      Hreadyout = 1'b1;
      #1;
      chk("t5_readyin_hi", Hreadyin, 1);
      tick();
      chk("t5_release", Hgrant,    0);
      chk("t5_ho",      dut.state, ARB_HANDOVER);
      chk("t5_wdata",   Hwdata,    32'h1234_5678);
      tick();
      chk("t5_grant2",  Hgrant, 4'b0100);

      // asynchronous reset in the middle of a burst
      do_reset();
      Hbusreq = 4'b0100;
      tick();
      chk("t6_grant2", Hgrant, 4'b0100);
      trans[2] = HTRANS_NONSEQ; addr[2] = 32'h4000_0000;
      tick();
      trans[2] = HTRANS_SEQ; addr[2] = 32'h4000_0004;
      #1;
      chk("t6_seq", Htrans, HTRANS_SEQ);
      #2;
      Hreset = 1'b1;
      #1;
      chk("t6_rst_grant",  Hgrant,    0);
      chk("t6_rst_trans",  Htrans,    0);
      chk("t6_rst_master", Hmaster,   0);
      chk("t6_rst_addr",   Haddr,     0);
      chk("t6_rst_state",  dut.state, ARB_IDLE);
      clear_inputs();
      Hreset = 1'b0;
      tick();
      chk("t6_after", Hgrant, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/ahb_master_arbiter.md
Name: ahb_master_arbiter

Overview:
- Shares the single AHB slave port of Bridge_top between NUM_MASTERS AHB masters.
- Arbitrates Hbusreq with a round-robin policy and issues a one-hot Hgrant.
- Muxes the owner's address/control toward the bridge, and the data-phase owner's Hwdata one pipeline stage later.
- Hands ownership over only at transfer boundaries, so bursts and pending data phases are never split.

Parameters:
- NUM_MASTERS, 4, number of requesting masters (2..8)
- ADDR_W, 32, address width
- DATA_W, 32, write data width
- MAX_HOLD, 16, accepted beats after which a requesting owner must yield at its next IDLE if others are waiting

Ports:
- Hclk  in  1  system clock, all state on rising edge
- Hreset  in  1  asynchronous active-high reset
- Hbusreq  in  NUM_MASTERS  per-master bus request
- M_Haddr  in  NUM_MASTERS*ADDR_W  flattened master addresses (master i at slice i)
- M_Hwdata  in  NUM_MASTERS*DATA_W  flattened master write data
- M_Hwrite  in  NUM_MASTERS  per-master write flag
- M_Htrans  in  NUM_MASTERS*2  flattened master Htrans
- Hreadyout  in  1  ready from Bridge_top
- Hgrant  out  NUM_MASTERS  one-hot grant, registered
- Hmaster  out  clog2(NUM_MASTERS)  address-phase owner index, registered
- Haddr  out  ADDR_W  to bridge
- Hwdata  out  DATA_W  to bridge
- Hwrite  out  1  to bridge
- Htrans  out  2  to bridge
- Hreadyin  out  1  to bridge, equals Hreadyout

Behaviour:
Reset (async, Hreset=1):
- State ARB_IDLE; Hgrant=0; Hmaster=0; Hmaster_data=0; rr pointer=0; beat_cnt=0.
- Bridge outputs: Htrans=IDLE (2'b00), Haddr=0, Hwrite=0, Hwdata=0.
- Any in-flight transfer is dropped.

Mux rules:
- In ARB_OWN: Haddr, Hwrite and Htrans forward M_* of Hmaster combinationally.
- Outside ARB_OWN: Htrans is forced IDLE; Haddr and Hwrite are forced 0.
- Hmaster_data (internal register) loads Hmaster on every edge with Hreadyout=1.
- Hwdata = M_Hwdata[Hmaster_data].

ARB_IDLE:
- If any Hbusreq is sampled at edge k, the round-robin winner (search from pointer upward, wrapping) is granted.
- Hgrant and Hmaster are valid from edge k.
- beat_cnt is cleared, pointer is set to winner+1 (mod NUM_MASTERS), and the state moves to ARB_OWN.

ARB_OWN:
- beat_cnt increments, saturating at MAX_HOLD, on each edge with Hreadyout=1 and owner Htrans in {NONSEQ, SEQ}.
- Release happens at an edge with Hreadyout=1 AND owner Htrans=IDLE AND either:
  - owner Hbusreq=0, or
  - beat_cnt>=MAX_HOLD and another master requests.
- On release: Hgrant=0 and the state moves to ARB_HANDOVER.
- BUSY, SEQ and NONSEQ cycles are never release points.
- The owner dropping Hbusreq mid-burst does not release; the grant is held until IDLE.

ARB_HANDOVER:
- Htrans is forced IDLE for at least one cycle while the old data phase completes.
- On an edge with Hreadyout=1:
  - if any request is pending, grant the round-robin winner and go to ARB_OWN;
  - otherwise go to ARB_IDLE.
- A sole requester that just released is re-granted after this one-cycle gap.

Boundary and latency rules:
- Simultaneous requests resolve by pointer order.
- Hreadyout=0 freezes state, beat_cnt and Hmaster_data.
- Minimum latency from request to grant is 1 edge; owner-to-owner switch takes 2 edges.

Decomposition:
- Package ahb_arb_pkg:
  - HTRANS_IDLE/BUSY/NONSEQ/SEQ constants
  - arb_state_t {ARB_IDLE, ARB_OWN, ARB_HANDOVER}
  - MIDX_W = clog2(NUM_MASTERS) helper
- Sub-module rr_picker: combinational round-robin search.
  - Inputs: request vector, pointer.
  - Outputs: winner index, any_req.

Test Plan:
1. Single request: reset, then Hbusreq=4'b0010 -> Hgrant=4'b0010 and Hmaster=1 one edge later. Master 1 NONSEQ write to 0x8000_0004 with Hwdata 0xA5A5_A5A5 -> bridge sees Haddr=0x8000_0004, then Hwdata=0xA5A5_A5A5 in the next cycle.
2. Simultaneous requests: Hbusreq=4'b1111 with every master releasing after one beat -> grant order 0,1,2,3,0, with a one-cycle Htrans=IDLE gap between owners.
3. Burst protection: master 0 in a 4-beat SEQ burst while master 2 requests, Hbusreq0 dropped at beat 2 -> grant stays with 0 until its IDLE, then master 2 is granted after HANDOVER.
4. MAX_HOLD=4: master 0 holds Hbusreq for 10 beats with IDLE after beat 5 while master 3 requests -> release at that IDLE, and master 3 is granted.
5. Wait states: Hreadyout=0 for 3 cycles during master 1's data phase, owner driving IDLE -> no handover until Hreadyout=1, and Hwdata stays on master 1's data throughout.
6. Reset mid-burst: Hreset pulsed asynchronously mid-SEQ -> Hgrant=0, Htrans=00 and state ARB_IDLE immediately, with no clock edge required.
